// File: rtl/game_pkg.sv
// Shared game definitions for the OLED driving game.
//   - FSM state encoding used by the collision/lives manager and its HUD consumers
//   - OLED geometry and the derived pixel count and pixel-index width
//   - is_active(): true in the states where the game is running
package game_pkg;

  localparam int OLED_W     = 96;
  localparam int OLED_H     = 64;
  localparam int NUM_PIXELS = OLED_W * OLED_H;
  localparam int PIX_W      = $clog2(NUM_PIXELS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_HIT     = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  function automatic logic is_active(input state_t s);
    return (s == ST_PLAYING) || (s == ST_HIT);
  endfunction

endpackage

// File: rtl/frame_tick_detect.sv
// Frame boundary detector for the OLED pixel scan.
// Registers the previous pixel index and emits a registered one-clock
// frame_end when the scan wraps back to pixel 0. Holding pixel_index at 0
// for many clocks still yields a single tick, because pix_prev is 0 from
// the second clock onwards.
// Ports:
//   clock_25mhz  in   system clock
//   reset_n      in   asynchronous active-low reset
//   pixel_index  in   current OLED pixel index
//   frame_end    out  one-clock pulse, one clock after pixel_index reaches 0
module frame_tick_detect #(
  parameter int PIX_W = 13
) (
  input  logic             clock_25mhz,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] pixel_index,
  output logic             frame_end
);

  logic [PIX_W-1:0] pix_prev;

  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      pix_prev  <= '0;
      frame_end <= 1'b0;
    end else begin
      pix_prev  <= pixel_index;
      frame_end <= (pixel_index == '0) && (pix_prev != '0);
    end
  end

endmodule

// File: rtl/collision_lives_manager.sv
// Collision and lives manager.
// Watches the player and obstacle hitboxes over each OLED frame, charges a
// life when they overlap, runs a post-hit invulnerability window, owns
// game_active and keeps a saturating survived-frames score for the HUD.
// Ports:
//   clock_25mhz         in   system clock
//   reset_n             in   asynchronous active-low reset
//   pixel_index         in   current OLED pixel index
//   is_obstacle_hitbox  in   obstacle occupies pixel_index
//   is_player_hitbox    in   player car occupies pixel_index
//   start_pulse         in   single-cycle start/restart request
//   game_active         out  high in PLAYING and HIT
//   lives               out  remaining lives
//   invuln              out  high in HIT
//   collision_pulse     out  one-cycle pulse when a life is lost
//   game_over           out  high in OVER
//   score               out  frames survived this game, saturating
module collision_lives_manager
  import game_pkg::*;
#(
  parameter int NUM_PIXELS    = game_pkg::NUM_PIXELS,
  parameter int MAX_LIVES     = 3,
  parameter int LIVES_W       = 2,
  parameter int INVULN_FRAMES = 60,
  parameter int SCORE_W       = 16
) (
  input  logic                          clock_25mhz,
  input  logic                          reset_n,
  input  logic [$clog2(NUM_PIXELS)-1:0] pixel_index,
  input  logic                          is_obstacle_hitbox,
  input  logic                          is_player_hitbox,
  input  logic                          start_pulse,
  output logic                          game_active,
  output logic [LIVES_W-1:0]            lives,
  output logic                          invuln,
  output logic                          collision_pulse,
  output logic                          game_over,
  output logic [SCORE_W-1:0]            score
);

  localparam int IDX_W = $clog2(NUM_PIXELS);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  state_t             state,     state_nxt;
  logic [LIVES_W-1:0] lives_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [7:0]         inv_cnt,   inv_nxt;
  logic               hit_seen,  hit_nxt;
  logic               pulse_nxt;
  logic               frame_end;
  logic               overlap;

  frame_tick_detect #(
    .PIX_W (IDX_W)
  ) u_tick (
    .clock_25mhz (clock_25mhz),
    .reset_n     (reset_n),
    .pixel_index (pixel_index),
    .frame_end   (frame_end)
  );

  assign overlap = is_obstacle_hitbox && is_player_hitbox && is_active(state);

  always_comb begin
    state_nxt = state;
    lives_nxt = lives;
    score_nxt = score;
    inv_nxt   = inv_cnt;
    pulse_nxt = 1'b0;
    hit_nxt   = hit_seen;

    // An overlap in the frame_end cycle belongs to the frame that is starting.
    if (frame_end) begin
      hit_nxt = overlap;
    end else if (overlap) begin
      hit_nxt = 1'b1;
    end

    unique case (state)
      ST_IDLE, ST_OVER: begin
        // Start beats a coincident frame_end: the old frame is never scored.
        if (start_pulse) begin
          state_nxt = ST_PLAYING;
          lives_nxt = LIVES_W'(MAX_LIVES);
          score_nxt = '0;
          hit_nxt   = 1'b0;
        end
      end
      ST_PLAYING: begin
        if (frame_end) begin
          if (hit_seen) begin
            pulse_nxt = 1'b1;
            if (lives > LIVES_W'(1)) begin
              state_nxt = ST_HIT;
              lives_nxt = lives - LIVES_W'(1);
              inv_nxt   = 8'(INVULN_FRAMES);
            end else begin
              state_nxt = ST_OVER;
              lives_nxt = '0;
            end
          end else begin
            score_nxt = sat_inc(score);
          end
        end
      end
      ST_HIT: begin
        // Overlaps are ignored while invulnerable; the frame still scores.
        if (frame_end) begin
          score_nxt = sat_inc(score);
          inv_nxt   = inv_cnt - 8'd1;
          if (inv_cnt == 8'd1) begin
            state_nxt = ST_PLAYING;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      lives           <= '0;
      score           <= '0;
      inv_cnt         <= '0;
      hit_seen        <= 1'b0;
      collision_pulse <= 1'b0;
    end else begin
      state           <= state_nxt;
      lives           <= lives_nxt;
      score           <= score_nxt;
      inv_cnt         <= inv_nxt;
      hit_seen        <= hit_nxt;
      collision_pulse <= pulse_nxt;
    end
  end

  // Status flags decode straight from the state register, so game_active
  // falls in the very cycle OVER is entered.
  assign game_active = is_active(state);
  assign invuln      = (state == ST_HIT);
  assign game_over   = (state == ST_OVER);

endmodule

// File: tb/tb_collision_lives_manager.sv
module tb_collision_lives_manager;

  localparam int MAX_LIVES     = 3;
  localparam int LIVES_W       = 2;
  localparam int INVULN_FRAMES = 60;
  localparam int SCORE_W       = 16;
  localparam int SCORE_MAX     = (1 << SCORE_W) - 1;

  logic               clock_25mhz = 1'b0;
  logic               reset_n = 1'b0;
  logic [12:0]        pixel_index = '0;
  logic               is_obstacle_hitbox = 1'b0;
  logic               is_player_hitbox = 1'b0;
  logic               start_pulse = 1'b0;
  logic               game_active;
  logic [LIVES_W-1:0] lives;
  logic               invuln;
  logic               collision_pulse;
  logic               game_over;
  logic [SCORE_W-1:0] score;

  collision_lives_manager #(
    .MAX_LIVES     (MAX_LIVES),
    .LIVES_W       (LIVES_W),
    .INVULN_FRAMES (INVULN_FRAMES),
    .SCORE_W       (SCORE_W)
  ) dut (
    .clock_25mhz        (clock_25mhz),
    .reset_n            (reset_n),
    .pixel_index        (pixel_index),
    .is_obstacle_hitbox (is_obstacle_hitbox),
    .is_player_hitbox   (is_player_hitbox),
    .start_pulse        (start_pulse),
    .game_active        (game_active),
    .lives              (lives),
    .invuln             (invuln),
    .collision_pulse    (collision_pulse),
    .game_over          (game_over),
    .score              (score)
  );

  always #20 clock_25mhz = ~clock_25mhz;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] lives;
    logic [31:0] score;
    logic [31:0] active;
    logic [31:0] invuln;
    logic [31:0] over;
    logic [31:0] pulse;
  } exp_t;

  exp_t sb_q[$];

  // Reference model of the game state
  localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_OVER = 3;
  int m_state = M_IDLE;
  int m_lives = 0;
  int m_score = 0;
  int m_inv   = 0;
  bit m_hit   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t snap(input bit pulse);
    exp_t e;
    e.lives  = 32'(m_lives);
    e.score  = 32'(m_score);
    e.active = 32'((m_state == M_PLAY) || (m_state == M_HIT));
    e.invuln = 32'(m_state == M_HIT);
    e.over   = 32'(m_state == M_OVER);
    e.pulse  = 32'(pulse);
    return e;
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE; m_lives = 0; m_score = 0; m_inv = 0; m_hit = 1'b0;
  endfunction

  function automatic void model_load();
    m_state = M_PLAY; m_lives = MAX_LIVES; m_score = 0; m_hit = 1'b0;
  endfunction

  function automatic void model_score();
    if (m_score < SCORE_MAX) m_score++;
  endfunction

  // Applies one frame boundary; returns whether a life was lost.
  function automatic bit model_frame_end(input bit ovl_fe, input bit start_fe);
    bit was_active = (m_state == M_PLAY) || (m_state == M_HIT);
    bit pulse = 1'b0;
    bit loaded = 1'b0;
    case (m_state)
      M_IDLE, M_OVER: if (start_fe) begin model_load(); loaded = 1'b1; end
      M_PLAY: begin
        if (m_hit) begin
          pulse = 1'b1;
          if (m_lives > 1) begin m_state = M_HIT; m_lives--; m_inv = INVULN_FRAMES; end
          else begin m_state = M_OVER; m_lives = 0; end
        end else begin
          model_score();
        end
      end
      M_HIT: begin
        model_score();
        if (m_inv == 1) m_state = M_PLAY;
        m_inv--;
      end
      default: ;
    endcase
    if (!loaded) m_hit = ovl_fe && was_active;
    return pulse;
  endfunction

  task automatic tick();
    @(posedge clock_25mhz);
    #1;
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got lives %0d expected an entry", tag, lives);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_lives"},  32'(lives),           e.lives);
      check_val({tag, "_score"},  32'(score),           e.score);
      check_val({tag, "_active"}, 32'(game_active),     e.active);
      check_val({tag, "_invuln"}, 32'(invuln),          e.invuln);
      check_val({tag, "_over"},   32'(game_over),       e.over);
      check_val({tag, "_pulse"},  32'(collision_pulse), e.pulse);
    end
  endtask

  // mode: 0 clean, 1 overlap at pixel 500, 2 obstacle only, 3 player only
  task automatic run_frame(input int mode, input bit ovl_fe, input bit start_fe);
    bit pulse;
    pixel_index = '0;
    pulse = model_frame_end(ovl_fe, start_fe);
    sb_q.push_back(snap(pulse));
    tick();
    is_obstacle_hitbox = ovl_fe;
    is_player_hitbox   = ovl_fe;
    start_pulse        = start_fe;
    tick();
    is_obstacle_hitbox = 1'b0;
    is_player_hitbox   = 1'b0;
    start_pulse        = 1'b0;
    compare_outputs("frame");
    for (int p = 1; p < 15; p++) begin
      pixel_index = 13'(p);
      tick();
      if (p == 1) check_val("pulse_clear", 32'(collision_pulse), 32'd0);
    end
    if (mode != 0) begin
      pixel_index = 13'd500;
      is_obstacle_hitbox = (mode == 1) || (mode == 2);
      is_player_hitbox   = (mode == 1) || (mode == 3);
      if (mode == 1 && (m_state == M_PLAY || m_state == M_HIT)) m_hit = 1'b1;
      repeat (3) tick();
      is_obstacle_hitbox = 1'b0;
      is_player_hitbox   = 1'b0;
    end
  endtask

  task automatic start_game();
    pixel_index = 13'd1;
    start_pulse = 1'b1;
    if (m_state == M_IDLE || m_state == M_OVER) model_load();
    sb_q.push_back(snap(1'b0));
    tick();
    start_pulse = 1'b0;
    compare_outputs("start");
  endtask

  task automatic go_to_over();
    int guard = 0;
    while (m_state != M_OVER && guard < 400) begin
      run_frame((m_state == M_PLAY) ? 1 : 0, 1'b0, 1'b0);
      guard++;
    end
    check_val("reach_over", 32'(game_over), 32'd1);
  endtask

  initial begin
    // Reset state
    model_reset();
    repeat (3) tick();
    sb_q.push_back(snap(1'b0));
    compare_outputs("reset");
    reset_n = 1'b1;
    tick();
    sb_q.push_back(snap(1'b0));
    compare_outputs("idle");

    // 1: start and five clean frames (including near misses)
    start_game();
    run_frame(0, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0);
    run_frame(3, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0);
    check_val("t1_score", 32'(score), 32'd5);

    // 2: overlap at pixel 500 charges a life on the next frame boundary
    run_frame(1, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0);
    check_val("t2_lives", 32'(lives), 32'd2);
    check_val("t2_invuln", 32'(invuln), 32'd1);
    start_game();

    // 3: overlaps during invulnerability are ignored
    repeat (INVULN_FRAMES) run_frame(1, 1'b0, 1'b0);
    check_val("t3_invuln", 32'(invuln), 32'd0);
    check_val("t3_lives", 32'(lives), 32'd2);
    run_frame(0, 1'b0, 1'b0);
    check_val("t3_lives_after", 32'(lives), 32'd1);

    // 4: last life lost, then restart
    go_to_over();
    check_val("t4_active", 32'(game_active), 32'd0);
    check_val("t4_lives", 32'(lives), 32'd0);
    start_game();

    // 5: start coincident with frame_end in OVER; overlap in frame_end cycle
    go_to_over();
    run_frame(0, 1'b0, 1'b1);
    check_val("t5_score", 32'(score), 32'd0);
    run_frame(0, 1'b1, 1'b0);
    check_val("t5_no_charge", 32'(lives), 32'd3);
    run_frame(0, 1'b0, 1'b0);
    check_val("t5_charged", 32'(lives), 32'd2);

    // 6: asynchronous reset mid-HIT, then a long pixel-0 hold
    run_frame(0, 1'b0, 1'b0);
    @(posedge clock_25mhz);
    #7;
    reset_n = 1'b0;
    #1;
    check_val("arst_active", 32'(game_active), 32'd0);
    check_val("arst_lives", 32'(lives), 32'd0);
    check_val("arst_score", 32'(score), 32'd0);
    check_val("arst_invuln", 32'(invuln), 32'd0);
    check_val("arst_pulse", 32'(collision_pulse), 32'd0);
    check_val("arst_over", 32'(game_over), 32'd0);
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    pixel_index = 13'd5;
    tick();
    start_game();
    pixel_index = '0;
    void'(model_frame_end(1'b0, 1'b0));
    sb_q.push_back(snap(1'b0));
    repeat (10) tick();
    compare_outputs("hold0");
    check_val("hold0_score", 32'(score), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
